demux_1by2_stream: RTL and testbench
====================================

// Module: demux_1by2_stream
// PURPOSE
//  1-to-2 packet demultiplexer; the inverse of the team's 2:1 mux.
//  Routes one valid/ready input stream to one of two output channels.
//  The route is chosen by s_sel on a packet's first beat and held until that packet's last beat.
//  Each output has a one-entry register slice, so output data/valid/last are registered.
//  Sits between a shared producer and two independent consumers.
// PARAMETERS
//  W      8  data width in bits
//  CNT_W  8  width of the per-channel completed-packet counters
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  s_data    in   W      input beat data
//  s_valid   in   1      input beat valid
//  s_last    in   1      input beat is the last of its packet
//  s_sel     in   1      destination (0->y0, 1->y1); sampled on a packet's first beat only
//  s_ready   out  1      input beat accepted when s_valid && s_ready
//  y0_data   out  W      channel 0 data
//  y0_valid  out  1      channel 0 valid
//  y0_last   out  1      channel 0 last
//  y0_ready  in   1      channel 0 consumer ready
//  y1_data   out  W      channel 1 data
//  y1_valid  out  1      channel 1 valid
//  y1_last   out  1      channel 1 last
//  y1_ready  in   1      channel 1 consumer ready
//  busy      out  1      high while a packet is mid-route (state ROUTE)
//  cnt0      out  CNT_W  packets completed to y0, wraps mod 2^CNT_W
//  cnt1      out  CNT_W  packets completed to y1, wraps mod 2^CNT_W
// BEHAVIOUR
//  Reset (async, rst_n=0), all outputs and state cleared:
//   - state=IDLE, route_sel=0
//   - yk_valid=0, yk_data=0, yk_last=0
//   - cnt0=cnt1=0, busy=0
//   - Buffered beats are discarded; a packet cut mid-route is lost.
//  FSM with two states, IDLE and ROUTE:
//   - eff_sel = (state==IDLE) ? s_sel : route_sel.
//   - IDLE, beat accepted: route_sel<=s_sel. Go to ROUTE if !s_last; stay IDLE if s_last (1-beat packet).
//   - ROUTE: s_sel is ignored. An accepted beat with s_last returns to IDLE.
//  Handshake:
//   - s_ready = !yk_valid || yk_ready, with k = eff_sel.
//   - This is a combinational ready path; it is intentional, to keep full throughput.
//   - accept = s_valid && s_ready. On accept, the slice for k loads {s_data,s_last} and sets yk_valid.
//   - Latency: 1 cycle from accept to yk_valid.
//   - Throughput: 1 beat/cycle when the consumer holds ready high.
//  Output slices:
//   - yk_valid clears on yk_valid && yk_ready with no same-cycle load.
//   - Drain and load on the same cycle: valid stays 1 and the new data appears.
//   - While yk_valid && !yk_ready, yk_data and yk_last hold stable.
//   - The unselected channel is never loaded; it drains independently.
//  Counters: cntk increments on an accepted beat with s_last routed to k. Wraps from 2^CNT_W-1 to 0.
//  busy = (state==ROUTE), registered.
//  Boundary cases:
//   - s_valid=0: no state change.
//   - A stalled channel blocks the input only while it is the eff_sel target.
//   - s_sel toggling mid-packet has no effect.
// STRUCTURE
//  Package demux_pkg:
//   - localparams ST_IDLE=1'b0, ST_ROUTE=1'b1
//   - SEL_Y0=1'b0, SEL_Y1=1'b1
//  Sub-module demux_out_reg #(W):
//   - one-entry valid/ready slice carrying {data,last}
//   - instantiated twice
//  FSM, eff_sel, s_ready and counters live in the top.
// TESTING
//  T1 reset:
//   - stimulus: assert rst_n=0 mid-packet with y0_valid=1
//   - required: all valid=0, cnt=0, busy=0 immediately (async); after release, a new packet routes by s_sel
//  T2 single-beat packets:
//   - stimulus: W=8, ready held 1; send 0x11 (sel0,last), 0x22 (sel1,last), 0x33 (sel0,last)
//   - required: y0 gets 0x11 and 0x33, y1 gets 0x22, one cycle after each accept; cnt0=2, cnt1=1
//  T3 route lock:
//   - stimulus: 4-beat packet A0..A3 with sel=1 on beat 0; s_sel toggled on beats 1-3
//   - required: all 4 beats on y1; y1_last only on A3; busy=1 from after A0 until after A3
//  T4 backpressure:
//   - stimulus: y0_ready=0 while streaming 3 beats to y0
//   - required: s_ready=0 after the first beat; y0_data holds stable; releasing y0_ready drains 1 beat/cycle
//  T5 independent stall:
//   - stimulus: y0_ready=0 with y0_valid=1; then send a packet with sel=1
//   - required: the y1 packet flows at full rate; y0 keeps its beat unchanged
//  T6 counter wrap:
//   - stimulus: CNT_W=2; send 5 single-beat packets to y1
//   - required: cnt1 sequence 1,2,3,0,1; cnt0 stays 0

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared state and channel-select encodings for the 1:2 stream demux
package demux_pkg;
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_ROUTE = 1'b1;
    localparam logic SEL_Y0   = 1'b0;
    localparam logic SEL_Y1   = 1'b1;
endpackage

// File: rtl/demux_out_reg.sv
// demux_out_reg: one-entry valid/ready register slice carrying {data,last}
module demux_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         last_o,
    output logic         free_o
);
    logic [W-1:0] data_q;
    logic         valid_q;
    logic         last_q;

    // load has priority over drain so a same-cycle drain+load keeps valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (ld_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
            last_q  <= last_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign free_o  = !valid_q || ready_i;
endmodule

// File: rtl/demux_1by2_stream.sv
// demux_1by2_stream: routes a valid/ready packet stream to one of two channels, locked per packet
module demux_1by2_stream
    import demux_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     s_data,
    input  logic             s_valid,
    input  logic             s_last,
    input  logic             s_sel,
    output logic             s_ready,
    output logic [W-1:0]     y0_data,
    output logic             y0_valid,
    output logic             y0_last,
    input  logic             y0_ready,
    output logic [W-1:0]     y1_data,
    output logic             y1_valid,
    output logic             y1_last,
    input  logic             y1_ready,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    logic             state_q, state_d;
    logic             route_q, route_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic             eff_sel, accept, free0, free1;

    assign eff_sel = (state_q == ST_IDLE) ? s_sel : route_q;
    assign s_ready = (eff_sel == SEL_Y1) ? free1 : free0;
    assign accept  = s_valid && s_ready;

    demux_out_reg #(.W(W)) u_y0 (
        .clk(clk), .rst_n(rst_n),
        .ld_i(accept && eff_sel == SEL_Y0), .data_i(s_data), .last_i(s_last),
        .ready_i(y0_ready), .data_o(y0_data), .valid_o(y0_valid), .last_o(y0_last),
        .free_o(free0)
    );

    demux_out_reg #(.W(W)) u_y1 (
        .clk(clk), .rst_n(rst_n),
        .ld_i(accept && eff_sel == SEL_Y1), .data_i(s_data), .last_i(s_last),
        .ready_i(y1_ready), .data_o(y1_data), .valid_o(y1_valid), .last_o(y1_last),
        .free_o(free1)
    );

    // route lock: sample s_sel on a first beat, leave ROUTE on an accepted last beat
    always_comb begin
        state_d = state_q;
        route_d = route_q;
        cnt0_d  = cnt0_q + CNT_W'(accept && s_last && eff_sel == SEL_Y0);
        cnt1_d  = cnt1_q + CNT_W'(accept && s_last && eff_sel == SEL_Y1);
        if (accept) begin
            route_d = (state_q == ST_IDLE) ? s_sel : route_q;
            state_d = s_last ? ST_IDLE : ST_ROUTE;
        end
    end

    // state, route and packet counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            route_q <= SEL_Y0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign busy = (state_q == ST_ROUTE);
    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
endmodule

// File: tb/tb_demux_1by2_stream.sv
// tb_demux_1by2_stream: directed scoreboard bench for the 1:2 stream demux
module tb_demux_1by2_stream;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid, s_last, s_sel, s_ready;
    logic [7:0] y0_data, y1_data;
    logic       y0_valid, y0_last, y0_ready, y1_valid, y1_last, y1_ready, busy;
    logic [1:0] cnt0, cnt1;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         c0;
    logic       m_state = 1'b0;
    logic       m_route = 1'b0;

    demux_1by2_stream #(.W(8), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_sel(s_sel), .s_ready(s_ready),
        .y0_data(y0_data), .y0_valid(y0_valid), .y0_last(y0_last), .y0_ready(y0_ready),
        .y1_data(y1_data), .y1_valid(y1_valid), .y1_last(y1_last), .y1_ready(y1_ready),
        .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: pop on output handshakes, push on input accepts using a route-lock model
    always @(negedge clk) begin
        logic [8:0] x;
        logic       e;
        if (!rst_n) begin
            m_state = 1'b0;
            m_route = 1'b0;
            q0.delete();
            q1.delete();
        end else begin
            if (y0_valid && y0_ready) begin
                chk("y0_expected", q0.size() > 0, 1);
                if (q0.size() > 0) begin
                    x = q0.pop_front();
                    chk("y0_beat", {y0_last, y0_data}, x);
                end
            end
            if (y1_valid && y1_ready) begin
                chk("y1_expected", q1.size() > 0, 1);
                if (q1.size() > 0) begin
                    x = q1.pop_front();
                    chk("y1_beat", {y1_last, y1_data}, x);
                end
            end
            if (s_valid && s_ready) begin
                e = m_state ? m_route : s_sel;
                if (e) q1.push_back({s_last, s_data});
                else q0.push_back({s_last, s_data});
                if (!m_state) m_route = s_sel;
                m_state = !s_last;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic sel, input logic last);
        int n;
        s_data = d;
        s_sel = sel;
        s_last = last;
        s_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_ready && n < 50);
        if (!s_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_valid = 1'b0;
        y0_ready = 1'b1;
        y1_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        s_data = '0;
        s_valid = 1'b0;
        s_last = 1'b0;
        s_sel = 1'b0;
        y0_ready = 1'b1;
        y1_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_y0_valid", y0_valid, 0);
        chk("rst_y1_valid", y1_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnts", {cnt0, cnt1}, 0);
        chk("rst_y_data", {y0_data, y1_data, y0_last, y1_last}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // T1: async reset mid-packet with y0 holding a beat
        y0_ready = 1'b0;
        send(8'hA0, 1'b0, 1'b0);
        chk("t1_y0_valid_pre", y0_valid, 1);
        chk("t1_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_y0_valid_async", y0_valid, 0);
        chk("t1_busy_async", busy, 0);
        chk("t1_y0_data_async", y0_data, 0);
        chk("t1_cnt_async", {cnt0, cnt1}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        y0_ready = 1'b1;
        send(8'h5A, 1'b1, 1'b1);
        chk("t1_y1_valid_post", y1_valid, 1);
        chk("t1_y1_data_post", y1_data, 8'h5A);
        chk("t1_y0_valid_post", y0_valid, 0);
        chk("t1_cnt1_post", cnt1, 1);

        // T2: single-beat packets
        do_reset();
        send(8'h11, 1'b0, 1'b1);
        chk("t2_y0_11", {y0_valid, y0_data}, {1'b1, 8'h11});
        send(8'h22, 1'b1, 1'b1);
        chk("t2_y1_22", {y1_valid, y1_data}, {1'b1, 8'h22});
        send(8'h33, 1'b0, 1'b1);
        chk("t2_y0_33", {y0_valid, y0_data}, {1'b1, 8'h33});
        @(posedge clk);
        #1;
        chk("t2_cnt0", cnt0, 2);
        chk("t2_cnt1", cnt1, 1);
        chk("t2_drained", {y0_valid, y1_valid}, 0);

        // T3: route lock over a 4-beat packet
        do_reset();
        send(8'hA0, 1'b1, 1'b0);
        chk("t3_busy_a0", busy, 1);
        chk("t3_last_a0", {y1_valid, y1_last}, 2'b10);
        send(8'hA1, 1'b0, 1'b0);
        chk("t3_last_a1", {y1_valid, y1_last}, 2'b10);
        send(8'hA2, 1'b1, 1'b0);
        chk("t3_busy_a2", busy, 1);
        send(8'hA3, 1'b0, 1'b1);
        chk("t3_last_a3", {y1_valid, y1_last, y1_data}, {2'b11, 8'hA3});
        chk("t3_busy_a3", busy, 0);
        chk("t3_y0_idle", y0_valid, 0);
        chk("t3_cnts", {cnt0, cnt1}, 4'b0001);

        // T4: backpressure on y0
        do_reset();
        y0_ready = 1'b0;
        send(8'hB0, 1'b0, 1'b0);
        s_data = 8'hB1;
        s_sel = 1'b0;
        s_last = 1'b0;
        s_valid = 1'b1;
        @(negedge clk);
        chk("t4_s_ready_stall", s_ready, 0);
        chk("t4_hold0", y0_data, 8'hB0);
        repeat (2) @(negedge clk);
        chk("t4_s_ready_stall2", s_ready, 0);
        chk("t4_hold2", {y0_valid, y0_last, y0_data}, {2'b10, 8'hB0});
        @(posedge clk);
        #1 y0_ready = 1'b1;
        c0 = cyc;
        send(8'hB1, 1'b0, 1'b0);
        chk("t4_b1", y0_data, 8'hB1);
        send(8'hB2, 1'b0, 1'b1);
        chk("t4_b2", {y0_last, y0_data}, {1'b1, 8'hB2});
        chk("t4_rate", cyc - c0, 2);
        @(posedge clk);
        #1;
        chk("t4_drain", y0_valid, 0);
        chk("t4_cnt0", cnt0, 1);

        // T5: stalled y0 does not block a y1 packet
        do_reset();
        y0_ready = 1'b0;
        send(8'hC0, 1'b0, 1'b1);
        c0 = cyc;
        send(8'hD0, 1'b1, 1'b0);
        send(8'hD1, 1'b0, 1'b0);
        send(8'hD2, 1'b0, 1'b1);
        chk("t5_rate", cyc - c0, 3);
        chk("t5_y0_hold", {y0_valid, y0_last, y0_data}, {2'b11, 8'hC0});
        chk("t5_y1_d2", {y1_valid, y1_last, y1_data}, {2'b11, 8'hD2});
        y0_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_y0_drain", y0_valid, 0);

        // T6: 2-bit counter wrap on y1
        do_reset();
        send(8'h01, 1'b1, 1'b1);
        chk("t6_cnt1_1", cnt1, 1);
        send(8'h02, 1'b1, 1'b1);
        chk("t6_cnt1_2", cnt1, 2);
        send(8'h03, 1'b1, 1'b1);
        chk("t6_cnt1_3", cnt1, 3);
        send(8'h04, 1'b1, 1'b1);
        chk("t6_cnt1_0", cnt1, 0);
        send(8'h05, 1'b1, 1'b1);
        chk("t6_cnt1_1b", cnt1, 1);
        chk("t6_cnt0", cnt0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("end_q0_empty", q0.size(), 0);
        chk("end_q1_empty", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
